// File: rtl/cla_serial_sequencer_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead add/subtract engine.
package cla_serial_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nib_of(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_serial_sequencer_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; every carry is expanded directly from p, g and cin.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1, c2, c3;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_serial_sequencer.sv
// WIDTH-bit add/subtract built by stepping one cla4_slice across the operands, LS nibble first,
// with valid/ready on both sides and fully registered outputs.
module cla_serial_sequencer
  import cla_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB = nib_of(WIDTH);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_c4;
  logic               accept;

  assign sl_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign sl_b = b_q[SLICE_W*idx_q +: SLICE_W];

  cla4_slice u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .sum (sl_sum),
    .c4  (sl_c4)
  );

  // in_ready is a registered flag, so acceptance keys off the flop, not the state.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = sl_sum;
        carry_d = sl_c4;
        if (idx_q == LAST) begin
          cout_d  = sl_c4;
          // Overflow is judged against the already-inverted B so add and subtract share one rule.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[SLICE_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cla_serial_sequencer.sv
// Bench for cla_serial_sequencer: a 16-bit and a 4-bit build checked against an arithmetic model.
module tb_cla_serial_sequencer;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic        iv4, ir4, sub4, ov4, or4, co4, of4, busy4;
  logic [3:0]  a4, b4, sum4;

  int n_checks = 0;
  int n_fail   = 0;

  cla_serial_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  cla_serial_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_sub(sub4), .out_valid(ov4), .out_ready(or4), .out_sum(sum4),
    .out_cout(co4), .out_ovf(of4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer arithmetic; cout = unsigned carry / no-borrow, ovf = signed range escape.
  function automatic void model(input int w, input int a, input int b, input bit sub,
                                output int s, output bit co, output bit of);
    int m, r, sa, sb, sr;
    m  = 1 << w;
    r  = sub ? a - b : a + b;
    s  = ((r % m) + m) % m;
    co = sub ? (a >= b) : (r >= m);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sub ? sa - sb : sa + sb;
    of = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  // Drives one 16-bit op with out_ready=1, scrambling inputs after accept; returns result and latency.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] s, output logic co, output logic of, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum; co = out_cout; of = out_ovf;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; or4 = 1'b0;
    #3;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, busy} !== 21'd0) begin
      n_fail++; $display("FAIL reset16: got rdy=%b vld=%b sum=%h co=%b ov=%b busy=%b, want all 0",
                         in_ready, out_valid, out_sum, out_cout, out_ovf, busy);
    end
    n_checks++;
    if ({ir4, ov4, sum4, co4, of4, busy4} !== 9'd0) begin
      n_fail++; $display("FAIL reset4: got rdy=%b vld=%b sum=%h, want all 0", ir4, ov4, sum4);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_rdy: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_release_rdy: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va[5], vb[5], es[5], s;
    logic        vs[5], ec[5], eo[5], co, of;
    int          lat;
    va = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    vb = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run16(va[i], vb[i], vs[i], s, co, of, lat);
      n_checks++;
      if (s !== es[i] || co !== ec[i] || of !== eo[i]) begin
        n_fail++; $display("FAIL directed%0d: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                           i, s, co, of, es[i], ec[i], eo[i]);
      end
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL latency%0d: got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s;
    logic        sub, co, of;
    int          lat, es;
    bit          ec, eo;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      if (i < 4) begin a = {i[0], 15'h7FFF}; b = {i[1], 15'h0001}; end
      model(16, int'(a), int'(b), sub, es, ec, eo);
      run16(a, b, sub, s, co, of, lat);
      n_checks++;
      if (s !== 16'(es) || co !== ec || of !== eo) begin
        n_fail++; $display("FAIL random%0d %h%s%h: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                           i, a, sub ? "-" : "+", b, s, co, of, 16'(es), ec, eo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a1, b1, a2, b2, s0;
    logic        sub1, sub2, c0, o0;
    int          es, guard;
    bit          ec, eo;
    a1 = 16'($urandom); b1 = 16'($urandom); sub1 = 1'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); sub2 = 1'($urandom);
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_a = a1; in_b = b1; in_sub = sub1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = a2; in_b = b2; in_sub = sub2;
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    s0 = out_sum; c0 = out_cout; o0 = out_ovf;
    model(16, int'(a1), int'(b1), sub1, es, ec, eo);
    n_checks++;
    if (out_valid !== 1'b1 || s0 !== 16'(es) || c0 !== ec || o0 !== eo) begin
      n_fail++; $display("FAIL bp_first: got vld=%b sum=%h co=%b ov=%b want vld=1 sum=%h co=%b ov=%b",
                         out_valid, s0, c0, o0, 16'(es), ec, eo);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s0 || out_cout !== c0
          || out_ovf !== o0) begin
        n_fail++; $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h want vld=1 rdy=0 sum=%h",
                           i, out_valid, in_ready, out_sum, s0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_second_accept: got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 50) begin
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
      @(posedge clk); #1; guard++;
    end
    model(16, int'(a2), int'(b2), sub2, es, ec, eo);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'(es) || out_cout !== ec || out_ovf !== eo) begin
      n_fail++; $display("FAIL bp_second: got vld=%b sum=%h co=%b ov=%b want vld=1 sum=%h co=%b ov=%b",
                         out_valid, out_sum, out_cout, out_ovf, 16'(es), ec, eo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int es, guard, nres;
    bit ec, eo;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    model(16, int'(a), int'(b), 1'b0, es, ec, eo);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = 1'b0; out_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid) begin
        nres++;
        n_checks++;
        if (out_sum !== 16'(es) || out_cout !== ec || out_ovf !== eo) begin
          n_fail++; $display("FAIL b2b_result c%0d: got sum=%h want %h", c, out_sum, 16'(es));
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    out_ready = 1'b0;
    n_checks++;
    if (acc.size() < 4 || nres < 3) begin
      n_fail++; $display("FAIL b2b_count: got accepts=%0d results=%0d want >=4 >=3", acc.size(), nres);
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== 6) begin
        n_fail++; $display("FAIL b2b_gap%0d: got %0d want 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s;
    logic        co, of;
    int          lat, guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h1111; in_sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, busy} !== 21'd0) begin
      n_fail++; $display("FAIL mid_reset: got rdy=%b vld=%b sum=%h co=%b ov=%b busy=%b, want all 0",
                         in_ready, out_valid, out_sum, out_cout, out_ovf, busy);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_release_rdy: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_post_rdy: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL stale_valid%0d: got vld=%b busy=%b want 0 0", i, out_valid, busy);
      end
      @(posedge clk); #1;
    end
    run16(16'h00FF, 16'h0001, 1'b0, s, co, of, lat);
    n_checks++;
    if (s !== 16'h0100 || co !== 1'b0 || of !== 1'b0 || lat !== 5) begin
      n_fail++; $display("FAIL post_reset_op: got sum=%h co=%b ov=%b lat=%0d want 0100 0 0 5",
                         s, co, of, lat);
    end
  endtask

  task automatic test_w4();
    logic [3:0] a, b;
    logic       sub;
    int         lat, guard, es;
    bit         ec, eo;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin a = 4'h9; b = 4'h8; sub = 1'b0; end
      else begin a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom); end
      model(4, int'(a), int'(b), sub, es, ec, eo);
      guard = 0;
      while (!ir4 && guard < 20) begin @(posedge clk); #1; guard++; end
      iv4 = 1'b1; a4 = a; b4 = b; sub4 = sub; or4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0; lat = 1;
      while (!ov4 && lat < 20) begin
        a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
        @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (sum4 !== 4'(es) || co4 !== ec || of4 !== eo || lat !== 2) begin
        n_fail++; $display("FAIL w4_op%0d %h%s%h: got sum=%h co=%b ov=%b lat=%0d want %h %b %b 2",
                           i, a, sub ? "-" : "+", b, sum4, co4, of4, lat, 4'(es), ec, eo);
      end
      @(posedge clk); #1;
      or4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
